// File: rtl/dmem_axil_buffered.sv
// Word-organised data RAM with a valid/ready request channel and a 2-entry buffered response channel.
// Optional per-lane even parity with an error-injection hook is enabled by defining DMEM_PARITY_EN.
module dmem_axil_buffered #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
`ifdef DMEM_PARITY_EN
    input  logic                      inj_parity_err,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_write,
    output logic                      rsp_err
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned LSB    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]      word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  in_range;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  fl_valid;
    logic                  fl_write;
    logic                  fl_range_err;
    logic [DATA_WIDTH-1:0] fl_rdata_c;
    logic                  fl_err_c;

    logic [DATA_WIDTH-1:0] buf_rdata [2];
    logic [1:0]            buf_write;
    logic [1:0]            buf_err;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  buf_pop;

    assign word_idx = req_addr[ADDR_WIDTH-1:LSB];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign in_range = (32'(word_idx) < 32'(DEPTH));

    generate
        if (LSB > 0) begin : g_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^req_addr[LSB-1:0];
        end
    endgenerate

    // Credits count the in-flight read stage plus buffered entries; registered state only.
    assign req_ready = ((2'(fl_valid) + count) < 2'd2);
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_write & in_range;
    assign rd_en     = accept & ~req_write & in_range;

    // Block RAM: per-lane write enables, synchronous read, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_be[i]) begin
                    mem[mem_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[mem_idx];
        end
    end

`ifdef DMEM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] par_q;
    logic [BYTES-1:0] par_calc_c;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_be[i]) begin
                    par_mem[mem_idx][i] <= (^req_wdata[i*8 +: 8]) ^ inj_parity_err;
                end
            end
        end
        if (rd_en) begin
            par_q <= par_mem[mem_idx];
        end
    end

    always_comb begin
        par_calc_c = '0;
        for (int i = 0; i < BYTES; i++) begin
            par_calc_c[i] = ^ram_q[i*8 +: 8];
        end
    end

    assign fl_err_c = fl_range_err | (~fl_write & (|(par_calc_c ^ par_q)));
`else
    assign fl_err_c = fl_range_err;
`endif

    assign fl_rdata_c = (fl_write | fl_range_err) ? '0 : ram_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_valid     <= 1'b0;
            fl_write     <= 1'b0;
            fl_range_err <= 1'b0;
        end else begin
            fl_valid <= accept;
            if (accept) begin
                fl_write     <= req_write;
                fl_range_err <= ~in_range;
            end
        end
    end

    // In-flight result bypasses the buffer only when the buffer is empty and the sink is ready.
    assign buf_pop = (count != 2'd0) & rsp_ready;
    assign push    = fl_valid & ~((count == 2'd0) & rsp_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (buf_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(buf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_rdata[wr_ptr] <= fl_rdata_c;
            buf_write[wr_ptr] <= fl_write;
            buf_err[wr_ptr]   <= fl_err_c;
        end
    end

    assign rsp_valid = fl_valid | (count != 2'd0);

    always_comb begin
        rsp_rdata = '0;
        rsp_write = 1'b0;
        rsp_err   = 1'b0;
        if (count != 2'd0) begin
            rsp_rdata = buf_rdata[rd_ptr];
            rsp_write = buf_write[rd_ptr];
            rsp_err   = buf_err[rd_ptr];
        end else if (fl_valid) begin
            rsp_rdata = fl_rdata_c;
            rsp_write = fl_write;
            rsp_err   = fl_err_c;
        end
    end

endmodule

// File: tb/tb_dmem_axil_buffered.sv
// Directed bench for dmem_axil_buffered: latency, byte lanes, credits/backpressure, range errors, reset.
// Parity injection steps run only when DMEM_PARITY_EN is defined.
module tb_dmem_axil_buffered;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [13:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        inj_parity_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    dmem_axil_buffered #(
        .DATA_WIDTH(32),
        .DEPTH(1024),
        .ADDR_WIDTH(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_be(req_be),
        .req_wdata(req_wdata),
`ifdef DMEM_PARITY_EN
        .inj_parity_err(inj_parity_err),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_be         = 4'h0;
        inj_parity_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_addr = '0;
        req_wdata = '0;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_write", 64'(rsp_write), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Full write then read, 1-cycle latency
        req(1'b1, 14'h010, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_write", 64'(rsp_write), 64'd1);
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("wr_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        chk("wr_drained", 64'(rsp_valid), 64'd0);
        req(1'b0, 14'h010, 4'h0, 32'h0);
        tick();
        idle();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_rsp_err", 64'(rsp_err), 64'd0);
        chk("rd_rsp_write", 64'(rsp_write), 64'd0);
        tick();

        // Byte-lane merge with read immediately after write
        req(1'b1, 14'h020, 4'hF, 32'h11223344);
        tick();
        req(1'b1, 14'h020, 4'h4, 32'hAABBCCDD);
        tick();
        req(1'b0, 14'h020, 4'h0, 32'h0);
        tick();
        idle();
        chk("lane_rdata", 64'(rsp_rdata), 64'h11BB3344);
        tick();

        // Preload four consecutive words
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 14'(14'h100 + 4 * i), 4'hF, 32'hA0000000 + 32'(i));
            tick();
        end
        idle();
        tick();
        chk("preload_drained", 64'(rsp_valid), 64'd0);

        // Backpressure: only two credits
        rsp_ready = 1'b0;
        req(1'b0, 14'h100, 4'h0, 32'h0);
        chk("bp_ready0", 64'(req_ready), 64'd1);
        tick();
        req(1'b0, 14'h104, 4'h0, 32'h0);
        chk("bp_ready1", 64'(req_ready), 64'd1);
        tick();
        req(1'b0, 14'h108, 4'h0, 32'h0);
        chk("bp_ready2", 64'(req_ready), 64'd0);
        tick();
        chk("bp_ready3", 64'(req_ready), 64'd0);
        chk("bp_head_a", 64'(rsp_rdata), 64'hA0000000);
        tick();
        chk("bp_head_stable", 64'(rsp_rdata), 64'hA0000000);
        chk("bp_valid_held", 64'(rsp_valid), 64'd1);
        chk("bp_ready4", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_head_b", 64'(rsp_rdata), 64'hA0000001);
        chk("bp_ready_reopen", 64'(req_ready), 64'd1);
        tick();
        chk("bp_head_c", 64'(rsp_rdata), 64'hA0000002);
        req(1'b0, 14'h10C, 4'h0, 32'h0);
        tick();
        idle();
        chk("bp_head_d", 64'(rsp_rdata), 64'hA0000003);
        chk("bp_head_d_valid", 64'(rsp_valid), 64'd1);
        tick();
        chk("bp_drained", 64'(rsp_valid), 64'd0);

        // 16 back-to-back reads at full throughput
        for (int i = 0; i < 16; i++) begin
            req(1'b0, 14'(14'h100 + 4 * (i % 4)), 4'h0, 32'h0);
            chk($sformatf("b2b_ready_%0d", i), 64'(req_ready), 64'd1);
            tick();
            chk($sformatf("b2b_data_%0d", i), 64'(rsp_rdata), 64'hA0000000 + 64'(i % 4));
        end
        idle();
        tick();

        // Out-of-range write and read; last valid word and word 0 unaffected
        req(1'b1, 14'h000, 4'hF, 32'h0BADF00D);
        tick();
        req(1'b1, 14'h0FFC, 4'hF, 32'h5A5A5A5A);
        tick();
        req(1'b1, 14'h1000, 4'hF, 32'hFFFFFFFF);
        tick();
        chk("oor_wr_err", 64'(rsp_err), 64'd1);
        chk("oor_wr_rdata", 64'(rsp_rdata), 64'd0);
        chk("oor_wr_write", 64'(rsp_write), 64'd1);
        req(1'b0, 14'h1000, 4'h0, 32'h0);
        tick();
        chk("oor_rd_err", 64'(rsp_err), 64'd1);
        chk("oor_rd_rdata", 64'(rsp_rdata), 64'd0);
        req(1'b0, 14'h000, 4'h0, 32'h0);
        tick();
        chk("word0_rdata", 64'(rsp_rdata), 64'h0BADF00D);
        chk("word0_err", 64'(rsp_err), 64'd0);
        req(1'b0, 14'h0FFC, 4'h0, 32'h0);
        tick();
        idle();
        chk("last_word_rdata", 64'(rsp_rdata), 64'h5A5A5A5A);
        chk("last_word_err", 64'(rsp_err), 64'd0);
        tick();

        // Reset with two buffered responses
        rsp_ready = 1'b0;
        req(1'b0, 14'h010, 4'h0, 32'h0);
        tick();
        req(1'b0, 14'h020, 4'h0, 32'h0);
        tick();
        idle();
        tick();
        chk("full_valid", 64'(rsp_valid), 64'd1);
        chk("full_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst2_ready", 64'(req_ready), 64'd1);
        chk("rst2_valid", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b1;
        req(1'b0, 14'h010, 4'h0, 32'h0);
        tick();
        idle();
        chk("rst2_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        tick();

`ifdef DMEM_PARITY_EN
        // Injected parity error on one lane
        req(1'b1, 14'h030, 4'h1, 32'h00000055);
        inj_parity_err = 1'b1;
        tick();
        idle();
        req(1'b0, 14'h030, 4'h0, 32'h0);
        tick();
        idle();
        chk("parity_err", 64'(rsp_err), 64'd1);
        chk("parity_lane0", 64'(rsp_rdata[7:0]), 64'h55);
        tick();
        req(1'b0, 14'h010, 4'h0, 32'h0);
        tick();
        idle();
        chk("parity_clean", 64'(rsp_err), 64'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_axil_buffered.md
Name: dmem_axil_buffered

Overview:
- Parametrised, word-organised data memory with one request channel (read or write, valid/ready) and one response channel (valid/ready).
- Response path holds a 2-entry buffer, so back-to-back requests run at full throughput and sink stalls never lose data.
- Adds range checking with an error response and per-lane byte writes of configurable width.
- Sits behind the SoC's AXI4-Lite slave adapter as the data RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_WIDTH, 14, byte-address width.
- Word index = addr >> log2(BYTES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address; low log2(BYTES) bits ignored.
- req_be  in  BYTES  byte-lane write enables; ignored for reads.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_write  out  1  echoes req_write of the response's request.
- rsp_err  out  1  word index was >= DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0.
  - req_ready=1 from the first cycle after release.
  - Buffer empty, in-flight flag clear.
  - Memory contents are NOT cleared.
  - Reset mid-transaction drops all in-flight and buffered responses; a write whose accept edge preceded reset stays committed.
- Storage: single synchronous-read RAM, DEPTH x DATA_WIDTH, per-lane write enables; must map to block RAM.
- Accept rule: accept = req_valid & req_ready.
- Write:
  - On the accept edge, lanes with req_be[i]=1 are updated; other lanes keep their old value.
  - req_be = 0 is a legal no-op write; it still returns a response.
- Read:
  - RAM output is valid one edge after accept (in-flight stage).
  - Response is pushed into the buffer on that edge.
- Latency: with an empty buffer and rsp_ready=1, rsp_valid is high the cycle after the accept edge (1-cycle latency).
- Credits: outstanding = in_flight + buffer occupancy (0..2); req_ready = (outstanding < 2).
  - req_ready is combinational from registered state only; no path from req_valid.
  - A pop in the same cycle does not raise req_ready that cycle.
  - Sustained rsp_ready=1: one request accepted every cycle.
- Buffer: 2-entry FIFO.
  - rsp_* reflect the head entry.
  - Push and pop on the same edge are both honoured.
  - Order is strictly preserved.
  - Head fields stay stable while rsp_valid=1 and rsp_ready=0.
- Out-of-range (word index >= DEPTH):
  - Write suppressed.
  - Response carries rsp_err=1 and rsp_rdata=0.
  - Consumes a credit like any other request.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data. No same-cycle collision exists on the single request channel.
- Address wrap: none; addresses beyond DEPTH are errors, not aliases.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Memory stores one even-parity bit per byte lane, written with that lane.
  - On read, recomputed parity is compared per lane; any mismatch sets rsp_err=1, with rsp_rdata still returning the stored data.
  - Adds input port inj_parity_err (1 bit); when high on a write accept, the stored parity bits of the written lanes are inverted (test hook).
- Undefined:
  - No parity storage and no inj_parity_err port.
  - rsp_err reflects range errors only.

Test Plan:
- Reset then write addr 0x010, be=1111, data 0xDEADBEEF; read 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid high 1 cycle after accept.
- Write 0x020 = 0x11223344, then write be=0100 data 0xAABBCCDD; read -> 0x11BB3344.
- rsp_ready=0 with 4 reads of consecutive words offered -> exactly 2 accepted, req_ready=0 afterwards; raise rsp_ready -> responses in order, data intact, then the remaining 2 accepted.
- 16 back-to-back reads with rsp_ready=1 -> req_ready stays 1 and one response per cycle.
- Write to word index DEPTH (byte addr 0x1000 at defaults), then read it -> both responses rsp_err=1, rdata=0; word 0 unchanged.
- Assert rst while buffer holds 2 responses -> rsp_valid=0 immediately; after release req_ready=1; previously written data still readable.
- With DMEM_PARITY_EN: write with inj_parity_err=1, be=0001, then read -> rsp_err=1.
